muldiv_ctrl: RTL

Multi-cycle sequencer for the RV32 M-extension. It replaces fixed `wait_mul`/`wait_div` stall counting with a real FSM: a registered multiplier with configurable latency and a 1-bit/cycle restoring divider with RISC-V-correct sign, divide-by-zero and overflow handling. It sits beside the ALU in the EXECUTE stage. The core raises `start` with operands and holds EXECUTE while `should_stall` is high.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_ctrl_if.sv | 23 ++
 rtl/muldiv_ctrl_divu_step.sv | 27 ++
 rtl/muldiv_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the RV32 M-extension multi-cycle unit.
// Imported by the controller and the divider step.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int unsigned DIV_ITERS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

  // Negating INT_MIN wraps back to 0x80000000, which is its correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      return 32'd0 - v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Core <-> muldiv handshake bundle: the core is the master, the unit the slave.
interface muldiv_ctrl_if;

  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        should_stall;

  modport master (
    output start, op, rs1_val, rs2_val,
    input  result, done, busy, should_stall
  );

  modport slave (
    input  start, op, rs1_val, rs2_val,
    output result, done, busy, should_stall
  );

endinterface

// File: rtl/muldiv_ctrl_divu_step.sv
// One restoring-division iteration: shift in the next dividend bit and subtract
// the divisor when it fits.
module divu_step
  import muldiv_pkg::*;
(
  input  logic [31:0] rem_i,
  input  logic        dividend_bit_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        quot_bit_o
);

  logic [32:0] trial;

  // The trial value can exceed 32 bits, but the difference never does.
  always_comb begin
    trial = {rem_i, dividend_bit_i};
    if (trial >= {1'b0, divisor_i}) begin
      quot_bit_o = 1'b1;
      rem_o      = trial[31:0] - divisor_i;
    end else begin
      quot_bit_o = 1'b0;
      rem_o      = trial[31:0];
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32 M-extension sequencer: pipelined multiplier plus a 1-bit/cycle restoring
// divider with RISC-V sign, divide-by-zero and overflow semantics.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned XLEN        = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_ctrl_if.slave bus
);

  state_e               state_q, state_d;
  op_e                  op_q, op_d, op_in;
  logic [XLEN-1:0]      a_q, a_d, b_q, b_d, rem_q, rem_d, result_q, result_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [MUL_LATENCY-1:0] vld_q, vld_d;
  logic                 neg_q, neg_d, done_q, done_d, busy_q, busy_d;
  logic                 accept, in_signed, special, a_signed, b_signed;
  logic [63:0]          a_ext, b_ext, product, mul_out;
  logic [XLEN-1:0]      step_rem, fix_val;
  logic                 step_bit;

  assign op_in     = op_e'(bus.op);
  assign accept    = (state_q == ST_IDLE) && bus.start;
  assign in_signed = ~bus.op[0];  // div and rem are the even (signed) encodings
  assign special   = (bus.rs2_val == 32'd0) ||
                     (in_signed && (bus.rs1_val == INT_MIN) && (bus.rs2_val == ALL_ONES));

  assign a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU);
  assign b_signed = (op_q == OP_MULH);
  assign a_ext    = {{32{a_signed & a_q[XLEN-1]}}, a_q};
  assign b_ext    = {{32{b_signed & b_q[XLEN-1]}}, b_q};
  assign product  = a_ext * b_ext;
  assign fix_val  = op_q[1] ? rem_q : a_q;

  // The final stage of the multiplier pipe is result_q itself.
  if (MUL_LATENCY > 1) begin : g_pipe
    logic [63:0] pipe_q [MUL_LATENCY-1];
    logic [63:0] pipe_d [MUL_LATENCY-1];

    always_comb begin
      pipe_d[0] = product;
      for (int i = 1; i < MUL_LATENCY - 1; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < MUL_LATENCY - 1; i++) begin
          pipe_q[i] <= 64'd0;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign mul_out = pipe_q[MUL_LATENCY-2];
  end else begin : g_nopipe
    assign mul_out = product;
  end

  divu_step u_step (
    .rem_i          (rem_q),
    .dividend_bit_i (a_q[XLEN-1]),
    .divisor_i      (b_q),
    .rem_o          (step_rem),
    .quot_bit_o     (step_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.start) begin
          state_d = ST_IDLE;
        end else if (!bus.op[2]) begin
          state_d = ST_MUL;
        end else if (special) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_MUL:  state_d = vld_q[MUL_LATENCY-1] ? ST_DONE : ST_MUL;
      ST_DIV:  state_d = (cnt_q == 5'(DIV_ITERS - 1)) ? ST_FIX : ST_DIV;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    vld_d[0] = accept && !bus.op[2];
    for (int i = 1; i < MUL_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV) || (state_d == ST_FIX);
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d  = op_in;
          rem_d = 32'd0;
          cnt_d = 5'd0;
          if (!bus.op[2]) begin
            a_d   = bus.rs1_val;
            b_d   = bus.rs2_val;
            neg_d = 1'b0;
          end else begin
            a_d   = mag32(bus.rs1_val, in_signed);
            b_d   = mag32(bus.rs2_val, in_signed);
            neg_d = bus.op[1] ? (in_signed & bus.rs1_val[31])
                              : (in_signed & (bus.rs1_val[31] ^ bus.rs2_val[31]));
            if (special && !bus.op[1]) begin
              result_d = (bus.rs2_val == 32'd0) ? ALL_ONES : INT_MIN;
            end else if (special) begin
              result_d = (bus.rs2_val == 32'd0) ? bus.rs1_val : 32'd0;
            end else begin
              result_d = result_q;
            end
          end
        end else begin
          op_d = op_q;
        end
      end
      ST_MUL: begin
        if (vld_q[MUL_LATENCY-1]) begin
          result_d = (op_q == OP_MUL) ? mul_out[31:0] : mul_out[63:32];
        end else begin
          result_d = result_q;
        end
      end
      ST_DIV: begin
        a_d   = {a_q[XLEN-2:0], step_bit};
        rem_d = step_rem;
        cnt_d = cnt_q + 5'd1;
      end
      ST_FIX: begin
        result_d = neg_q ? (32'd0 - fix_val) : fix_val;
      end
      ST_DONE: begin
        result_d = result_q;
      end
      default: begin
        result_d = result_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_MUL;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      rem_q    <= 32'd0;
      cnt_q    <= 5'd0;
      vld_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;
  assign bus.should_stall = accept | busy_q;

endmodule
